// File: rtl/img_stream_pkg.sv
// Shared video stream types and the [1,2,1] vertical tap helper.
// Optional macro VBLUR_ROUND_EN: round the tap result half up.
package img_stream_pkg;

  localparam int IMAGE_W = 640;
  localparam int IMAGE_H = 480;

  localparam logic [3:0] PKT_TYPE_VIDEO = 4'h0;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic logic [7:0] blur121(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] c
  );
`ifdef VBLUR_ROUND_EN
    logic [10:0] s;
    s = ({3'b0, a} + {2'b0, b, 1'b0}
       + {3'b0, c} + 11'd2) >> 2;
    blur121 = (s > 11'd255) ? 8'hff : s[7:0];
`else
    logic [9:0] s;
    s = {2'b0, a} + {1'b0, b, 1'b0}
      + {2'b0, c};
    blur121 = s[9:2];
`endif
  endfunction

endpackage

// File: rtl/stream_vblur3_line_ram.sv
// One-line pixel store: 1 write, 1 synchronous read port.
// Read-before-write; read data holds while i_re is low.
module line_ram #(
  parameter int DEPTH = 640,
  parameter int AW    = 10,
  parameter int DW    = 24
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/stream_vblur3.sv
// Avalon-ST 3-tap [1,2,1]/4 vertical blur, two line buffers.
// Build option: VBLUR_ROUND_EN selects round-half-up results.
module stream_vblur3 #(
  parameter int IMAGE_W = img_stream_pkg::IMAGE_W,
  parameter int ADDR_W  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] sink_data,
  input  logic        sink_valid,
  output logic        sink_ready,
  input  logic        sink_sop,
  input  logic        sink_eop,
  output logic [23:0] source_data,
  output logic        source_valid,
  input  logic        source_ready,
  output logic        source_sop,
  output logic        source_eop,
  input  logic        mode
);

  import img_stream_pkg::*;

  logic              w_adv;
  logic              w_acc;
  logic              w_pix;
  logic              w_lb2_we;
  logic [ADDR_W-1:0] r_x;
  logic [1:0]        r_row;
  logic              r_pkt_video;

  logic              r_s1_valid;
  logic              r_s1_sop;
  logic              r_s1_eop;
  logic              r_s1_pix;
  logic              r_s1_blur;
  logic [1:0]        r_s1_row;
  logic [ADDR_W-1:0] r_s1_x;
  rgb_t              r_s1_data;

  rgb_t              w_lb1_q;
  rgb_t              w_lb2_q;
  rgb_t              w_a;
  rgb_t              w_b;
  rgb_t              w_c;
  rgb_t              w_f;
  rgb_t              w_out;

  logic              r_s2_valid;
  logic              r_s2_sop;
  logic              r_s2_eop;
  rgb_t              r_s2_data;

  assign w_adv      = ~r_s2_valid | source_ready;
  assign w_acc      = sink_valid & w_adv;
  assign w_pix      = w_acc & ~sink_sop & r_pkt_video;
  assign w_lb2_we   = w_adv & r_s1_valid & r_s1_pix;
  assign sink_ready = w_adv;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x         <= '0;
      r_row       <= '0;
      r_pkt_video <= 1'b0;
    end else begin
      unique case (1'b1)
        w_acc & sink_sop: begin
          r_pkt_video <=
            (sink_data[3:0] == PKT_TYPE_VIDEO);
          r_x   <= '0;
          r_row <= '0;
        end
        w_pix: begin
          if (r_x == ADDR_W'(IMAGE_W - 1)) begin
            r_x <= '0;
            if (r_row != 2'd2)
              r_row <= r_row + 2'd1;
          end else begin
            r_x <= r_x + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_sop   <= 1'b0;
      r_s1_eop   <= 1'b0;
      r_s1_pix   <= 1'b0;
      r_s1_blur  <= 1'b0;
      r_s1_row   <= '0;
      r_s1_x     <= '0;
      r_s1_data  <= '0;
    end else if (w_adv) begin
      r_s1_valid <= sink_valid;
      r_s1_sop   <= sink_sop;
      r_s1_eop   <= sink_eop;
      r_s1_pix   <= w_pix;
      r_s1_blur  <= w_pix & mode;
      r_s1_row   <= r_row;
      r_s1_x     <= r_x;
      r_s1_data  <= sink_data;
    end
  end

  line_ram #(
    .DEPTH (IMAGE_W),
    .AW    (ADDR_W),
    .DW    (24)
  ) u_lb1 (
    .clk     (clk),
    .i_we    (w_pix),
    .i_waddr (r_x),
    .i_wdata (sink_data),
    .i_re    (w_pix),
    .i_raddr (r_x),
    .o_rdata (w_lb1_q)
  );

  // lb2 takes the old row y-1 value once it has been read out of lb1
  line_ram #(
    .DEPTH (IMAGE_W),
    .AW    (ADDR_W),
    .DW    (24)
  ) u_lb2 (
    .clk     (clk),
    .i_we    (w_lb2_we),
    .i_waddr (r_s1_x),
    .i_wdata (w_lb1_q),
    .i_re    (w_pix),
    .i_raddr (r_x),
    .o_rdata (w_lb2_q)
  );

  always_comb begin
    w_c = r_s1_data;
    w_b = (r_s1_row == 2'd0) ? w_c : w_lb1_q;
    w_a = (r_s1_row == 2'd2) ? w_lb2_q : w_b;
    w_f.r = blur121(w_a.r, w_b.r, w_c.r);
    w_f.g = blur121(w_a.g, w_b.g, w_c.g);
    w_f.b = blur121(w_a.b, w_b.b, w_c.b);
    w_out = r_s1_blur ? w_f : r_s1_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_sop   <= 1'b0;
      r_s2_eop   <= 1'b0;
      r_s2_data  <= '0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      r_s2_sop   <= r_s1_sop;
      r_s2_eop   <= r_s1_eop;
      r_s2_data  <= w_out;
    end
  end

  assign source_valid = r_s2_valid;
  assign source_sop   = r_s2_sop;
  assign source_eop   = r_s2_eop;
  assign source_data  = r_s2_data;

endmodule
